// File: rtl/segre_pkg.sv
// Shared types for the SEGRE memory arbiter: word width, access size and
// the arbiter FSM state encoding.
package segre_pkg;

   localparam int WORD_SIZE = 32;

   // Access size of a memory operation (BYTE is the reset/default value).
   typedef enum logic [1:0] {
      BYTE,
      HALF,
      WORD
   } memop_data_type_e;

   // Arbiter FSM: IDLE, data access in flight, instruction fetch in flight.
   typedef enum logic [1:0] {
      IDLE,
      DATA,
      FETCH
   } arb_state_e;

endpackage

// File: rtl/segre_mem_arbiter_if.sv
// Memory-side bus of the arbiter.
// Handshake: the master raises mm_req_o together with stable mm_we_o,
// mm_type_o, mm_addr_o and mm_wr_data_o and holds all of them unchanged
// until the slave returns a one-cycle mm_ack_i (with mm_rd_data_i valid in
// that same cycle); the request counts as completed on the edge that ends
// the ack cycle, and mm_ack_i is meaningless while mm_req_o is low.
interface segre_mem_arbiter_if;
   import segre_pkg::*;

   logic                   mm_req_o;
   logic                   mm_we_o;
   memop_data_type_e       mm_type_o;
   logic [WORD_SIZE-1:0]   mm_addr_o;
   logic [WORD_SIZE-1:0]   mm_wr_data_o;
   logic                   mm_ack_i;
   logic [WORD_SIZE-1:0]   mm_rd_data_i;

   modport master (
      output mm_req_o,
      output mm_we_o,
      output mm_type_o,
      output mm_addr_o,
      output mm_wr_data_o,
      input  mm_ack_i,
      input  mm_rd_data_i
   );

   modport slave (
      input  mm_req_o,
      input  mm_we_o,
      input  mm_type_o,
      input  mm_addr_o,
      input  mm_wr_data_o,
      output mm_ack_i,
      output mm_rd_data_i
   );

endinterface

// File: rtl/segre_mem_arbiter.sv
// Arbitrates one shared memory port between instruction fetch (IF) and the
// data accesses of the memory stage. Data has fixed priority, only one bus
// transaction is outstanding, and a taken branch kills an in-flight fetch
// so its data never reaches IF.
module segre_mem_arbiter
   import segre_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rsn_i,
   // instruction fetch side
   input  logic                   if_req_i,
   input  logic [WORD_SIZE-1:0]   if_addr_i,
   output logic                   if_valid_o,
   output logic [WORD_SIZE-1:0]   if_data_o,
   // memory stage side
   input  logic                   mem_rd_i,
   input  logic                   mem_wr_i,
   input  memop_data_type_e       mem_type_i,
   input  logic [WORD_SIZE-1:0]   mem_addr_i,
   input  logic [WORD_SIZE-1:0]   mem_wr_data_i,
   output logic                   mem_valid_o,
   output logic [WORD_SIZE-1:0]   mem_rd_data_o,
   // pipeline control
   input  logic                   tkbr_i,
   output logic                   hazard_o,
   // shared memory bus
   segre_mem_arbiter_if.master    mm,
   // debug view of the FSM
   output arb_state_e             state_o
);

   arb_state_e state_q, state_d;
   logic       kill_q, kill_d;
   logic       data_req;
   logic       data_ack;
   logic       fetch_ack;
   logic       fetch_deliver;
   logic       enter_data;
   logic       enter_fetch;

   assign data_req  = mem_rd_i | mem_wr_i;
   assign data_ack  = (state_q == DATA)  && mm.mm_ack_i;
   assign fetch_ack = (state_q == FETCH) && mm.mm_ack_i;

   // A fetch flushed earlier, or in its own ack cycle, must not reach IF.
   assign fetch_deliver = fetch_ack && !(kill_q || tkbr_i);

   // The memory stage stalls until the cycle its own access is acknowledged.
   assign hazard_o = data_req && !data_ack;

   assign state_o = state_q;

   // Next-state and kill-flag logic; data wins over fetch, and an ack hands
   // the bus straight to a waiting requester without an IDLE bubble.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (data_req) begin
               state_d = DATA;
            end else if (if_req_i) begin
               state_d = FETCH;
            end
         end
         DATA: begin
            if (mm.mm_ack_i) begin
               state_d = if_req_i ? FETCH : IDLE;
            end
         end
         FETCH: begin
            if (mm.mm_ack_i) begin
               state_d = data_req ? DATA : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // The flag lives only while a fetch is (or is about to be) in flight.
      kill_d = (state_d == FETCH) && (kill_q || tkbr_i);
   end

   assign enter_data  = (state_d == DATA)  && (state_q != DATA);
   assign enter_fetch = (state_d == FETCH) && (state_q != FETCH);

   // FSM state and kill flag registers.
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         state_q <= IDLE;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         kill_q  <= kill_d;
      end
   end

   // Bus request registers: captured when a transaction starts, held until
   // its ack, after which only mm_req_o drops.
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         mm.mm_req_o     <= 1'b0;
         mm.mm_we_o      <= 1'b0;
         mm.mm_type_o    <= BYTE;
         mm.mm_addr_o    <= '0;
         mm.mm_wr_data_o <= '0;
      end else if (enter_data) begin
         mm.mm_req_o     <= 1'b1;
         mm.mm_we_o      <= mem_wr_i;
         mm.mm_type_o    <= mem_type_i;
         mm.mm_addr_o    <= mem_addr_i;
         mm.mm_wr_data_o <= mem_wr_data_i;
      end else if (enter_fetch) begin
         mm.mm_req_o     <= 1'b1;
         mm.mm_we_o      <= 1'b0;
         mm.mm_type_o    <= WORD;
         mm.mm_addr_o    <= if_addr_i;
         mm.mm_wr_data_o <= '0;
      end else if (mm.mm_ack_i && (state_q != IDLE)) begin
         mm.mm_req_o     <= 1'b0;
      end
   end

   // Completion pulses and returned data, one cycle after the ack.
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         mem_valid_o   <= 1'b0;
         mem_rd_data_o <= '0;
         if_valid_o    <= 1'b0;
         if_data_o     <= '0;
      end else begin
         mem_valid_o <= data_ack;
         if_valid_o  <= fetch_deliver;
         if (data_ack) begin
            mem_rd_data_o <= mm.mm_rd_data_i;
         end
         if (fetch_deliver) begin
            if_data_o <= mm.mm_rd_data_i;
         end
      end
   end

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Directed bench for segre_mem_arbiter: a memory model with programmable
// wait states, expected bus transactions and completion data queued as
// stimulus is issued, and monitors that pop and compare on every ack and
// every valid pulse.
module tb_segre_mem_arbiter;
   import segre_pkg::*;

   localparam int W = WORD_SIZE;

   typedef struct packed {
      logic             we;
      memop_data_type_e typ;
      logic [W-1:0]     addr;
      logic [W-1:0]     wdata;
   } bus_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic             rsn_i;
   logic             if_req_i;
   logic [W-1:0]     if_addr_i;
   logic             if_valid_o;
   logic [W-1:0]     if_data_o;
   logic             mem_rd_i;
   logic             mem_wr_i;
   memop_data_type_e mem_type_i;
   logic [W-1:0]     mem_addr_i;
   logic [W-1:0]     mem_wr_data_i;
   logic             mem_valid_o;
   logic [W-1:0]     mem_rd_data_o;
   logic             tkbr_i;
   logic             hazard_o;
   arb_state_e       state_o;

   segre_mem_arbiter_if mm_bus ();

   segre_mem_arbiter dut (
      .clk_i         (clk),
      .rsn_i         (rsn_i),
      .if_req_i      (if_req_i),
      .if_addr_i     (if_addr_i),
      .if_valid_o    (if_valid_o),
      .if_data_o     (if_data_o),
      .mem_rd_i      (mem_rd_i),
      .mem_wr_i      (mem_wr_i),
      .mem_type_i    (mem_type_i),
      .mem_addr_i    (mem_addr_i),
      .mem_wr_data_i (mem_wr_data_i),
      .mem_valid_o   (mem_valid_o),
      .mem_rd_data_o (mem_rd_data_o),
      .tkbr_i        (tkbr_i),
      .hazard_o      (hazard_o),
      .mm            (mm_bus.master),
      .state_o       (state_o)
   );

   // ---------------- memory model ----------------
   logic         mem_en = 1'b1;
   logic         ack_manual = 1'b0;
   logic         ack_model = 1'b0;
   logic [W-1:0] rdata_model = '0;
   int           delay = 0;
   int           cnt = 0;

   assign mm_bus.mm_ack_i     = mem_en ? ack_model : ack_manual;
   assign mm_bus.mm_rd_data_i = rdata_model;

   function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
      if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
      return a ^ 32'h1234_5678;
   endfunction

   // Acks a pending request after 'delay' wait cycles, one-cycle pulse.
   always @(negedge clk) begin
      if (!rsn_i || !mem_en) begin
         ack_model <= 1'b0;
         cnt       <= 0;
      end else begin
         ack_model <= 1'b0;
         if (mm_bus.mm_req_o) begin
            if (cnt == delay) begin
               ack_model   <= 1'b1;
               cnt         <= 0;
               rdata_model <= mem_word(mm_bus.mm_addr_o);
            end else begin
               cnt <= cnt + 1;
            end
         end else begin
            cnt <= 0;
         end
      end
   end

   // ---------------- scoreboard ----------------
   int           tests = 0;
   int           fails = 0;
   int           req_cycles = 0;
   logic [W-1:0] exp_mem_q[$];
   logic [W-1:0] exp_if_q[$];
   bus_t         exp_bus_q[$];
   int           valid_cyc_q[$];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name, input string msg);
      tests++;
      fails++;
      $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
   endtask

   task automatic push_bus(input logic we, input memop_data_type_e typ,
                           input logic [W-1:0] addr, input logic [W-1:0] wdata);
      bus_t b;
      b.we    = we;
      b.typ   = typ;
      b.addr  = addr;
      b.wdata = wdata;
      exp_bus_q.push_back(b);
   endtask

   // Monitor: bus transactions at ack time, completion pulses when seen.
   always begin
      bus_t act, exp;
      @(negedge clk);
      #1;
      if (rsn_i) begin
         if (mm_bus.mm_req_o) req_cycles++;
         if (mm_bus.mm_req_o && mm_bus.mm_ack_i) begin
            act.we    = mm_bus.mm_we_o;
            act.typ   = mm_bus.mm_type_o;
            act.addr  = mm_bus.mm_addr_o;
            act.wdata = mm_bus.mm_wr_data_o;
            if (exp_bus_q.size() == 0) begin
               fail_now("bus_txn", $sformatf("got unexpected txn %h", act));
            end else begin
               exp = exp_bus_q.pop_front();
               tests++;
               if (act !== exp) begin
                  fails++;
                  $display("FAIL bus_txn: got %h expected %h (cycle %0d)", act, exp, cyc);
               end
            end
         end
         if (mem_valid_o && if_valid_o) begin
            fail_now("valid_overlap", "got both valid pulses, expected at most one");
         end
         if (mem_valid_o) begin
            valid_cyc_q.push_back(cyc);
            if (exp_mem_q.size() == 0) fail_now("mem_valid", "got unexpected pulse, expected none");
            else check("mem_rd_data", mem_rd_data_o, exp_mem_q.pop_front());
         end
         if (if_valid_o) begin
            if (exp_if_q.size() == 0) fail_now("if_valid", "got unexpected pulse, expected none");
            else check("if_data", if_data_o, exp_if_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   // Memory-stage access held until hazard_o drops, which must be its ack.
   task automatic data_req(input logic rd, input logic wr, input memop_data_type_e typ,
                           input logic [W-1:0] addr, input logic [W-1:0] wdata,
                           output int req_cyc);
      bit done = 0;
      tick();
      mem_rd_i      = rd;
      mem_wr_i      = wr;
      mem_type_i    = typ;
      mem_addr_i    = addr;
      mem_wr_data_i = wdata;
      req_cyc       = cyc;
      for (int i = 0; i < 40 && !done; i++) begin
         sample();
         if (!hazard_o) begin
            done = 1;
            check("hazard_low_only_on_data_ack",
                  W'(mm_bus.mm_ack_i && (state_o == DATA)), W'(1));
         end
      end
      if (!done) fail_now("data_req_timeout", "got no hazard release, expected one");
      mem_rd_i = 1'b0;
      mem_wr_i = 1'b0;
   endtask

   task automatic wait_if_valid();
      bit done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         sample();
         if (if_valid_o) done = 1;
      end
      if (!done) fail_now("fetch_timeout", "got no if_valid_o, expected one");
      if_req_i = 1'b0;
   endtask

   task automatic fetch_req(input logic [W-1:0] addr);
      tick();
      if_req_i  = 1'b1;
      if_addr_i = addr;
      wait_if_valid();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_mm_req"},      W'(mm_bus.mm_req_o), W'(0));
      check({tag, "_mm_we"},       W'(mm_bus.mm_we_o), W'(0));
      check({tag, "_mm_type"},     W'(mm_bus.mm_type_o), W'(BYTE));
      check({tag, "_mm_addr"},     mm_bus.mm_addr_o, 32'h0);
      check({tag, "_mm_wr_data"},  mm_bus.mm_wr_data_o, 32'h0);
      check({tag, "_if_valid"},    W'(if_valid_o), W'(0));
      check({tag, "_if_data"},     if_data_o, 32'h0);
      check({tag, "_mem_valid"},   W'(mem_valid_o), W'(0));
      check({tag, "_mem_rd_data"}, mem_rd_data_o, 32'h0);
      check({tag, "_hazard"},      W'(hazard_o), W'(0));
      check({tag, "_state"},       W'(state_o), W'(IDLE));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test, expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed tests ----------------
   initial begin
      int rc;
      int rcs[4];
      int base;
      int snap;

      rsn_i = 1'b0;
      if_req_i = 1'b0;
      if_addr_i = '0;
      mem_rd_i = 1'b0;
      mem_wr_i = 1'b0;
      mem_type_i = BYTE;
      mem_addr_i = '0;
      mem_wr_data_i = '0;
      tkbr_i = 1'b0;

      // Reset state
      tick();
      tick();
      check_idle_outputs("reset");
      rsn_i = 1'b1;
      tick();

      // Single load with 2 wait states: req high 3 cycles, one valid pulse
      delay = 2;
      snap = req_cycles;
      push_bus(1'b0, WORD, 32'h100, 32'h0);
      exp_mem_q.push_back(32'hDEAD_BEEF);
      data_req(1'b1, 1'b0, WORD, 32'h100, 32'h0, rc);
      sample();
      sample();
      check("load_req_cycles", W'(req_cycles - snap), W'(3));

      // Store and fetch together: store first, fetch with no idle gap
      delay = 1;
      push_bus(1'b1, WORD, 32'h40, 32'hCAFE_F00D);
      push_bus(1'b0, WORD, 32'h80, 32'h0);
      exp_mem_q.push_back(32'h1234_5638);
      exp_if_q.push_back(32'h1234_56F8);
      fork
         begin
            data_req(1'b0, 1'b1, WORD, 32'h40, 32'hCAFE_F00D, rc);
            sample();
            check("store_then_fetch_req",  W'(mm_bus.mm_req_o), W'(1));
            check("store_then_fetch_we",   W'(mm_bus.mm_we_o), W'(0));
            check("store_then_fetch_addr", mm_bus.mm_addr_o, 32'h80);
         end
         fetch_req(32'h80);
      join
      tick();

      // Fetch killed by a taken branch, then the redirected fetch
      delay = 2;
      push_bus(1'b0, WORD, 32'h300, 32'h0);
      tick();
      if_req_i  = 1'b1;
      if_addr_i = 32'h300;
      tick();
      tkbr_i    = 1'b1;
      if_addr_i = 32'h200;
      push_bus(1'b0, WORD, 32'h200, 32'h0);
      exp_if_q.push_back(32'h1234_5478);
      tick();
      tkbr_i = 1'b0;
      wait_if_valid();
      tick();

      // Load arriving during a fetch waits, then follows without a bubble
      delay = 2;
      push_bus(1'b0, WORD, 32'h500, 32'h0);
      push_bus(1'b0, HALF, 32'h104, 32'h0);
      exp_if_q.push_back(32'h1234_5378);
      exp_mem_q.push_back(32'h1234_577C);
      fork
         fetch_req(32'h500);
         begin
            tick();
            tick();
            data_req(1'b1, 1'b0, HALF, 32'h104, 32'h0, rc);
         end
         begin
            bit seen = 0;
            for (int i = 0; i < 40 && !seen; i++) begin
               sample();
               if (mm_bus.mm_ack_i && state_o == FETCH) seen = 1;
            end
            if (!seen) fail_now("fetch_ack_timeout", "got no fetch ack, expected one");
            sample();
            check("load_after_fetch_addr",  mm_bus.mm_addr_o, 32'h104);
            check("load_after_fetch_req",   W'(mm_bus.mm_req_o), W'(1));
            check("load_after_fetch_state", W'(state_o), W'(DATA));
         end
      join
      tick();

      // Reset in the middle of a load, then a late ack
      mem_en     = 1'b0;
      ack_manual = 1'b0;
      tick();
      mem_rd_i   = 1'b1;
      mem_type_i = WORD;
      mem_addr_i = 32'h180;
      tick();
      tick();
      check("pre_reset_req", W'(mm_bus.mm_req_o), W'(1));
      rsn_i    = 1'b0;
      mem_rd_i = 1'b0;
      #1;
      check_idle_outputs("async_reset");
      tick();
      rsn_i      = 1'b1;
      snap       = req_cycles;
      ack_manual = 1'b1;
      tick();
      ack_manual = 1'b0;
      check("late_ack_state", W'(state_o), W'(IDLE));
      tick();
      tick();
      tick();
      check("late_ack_req_cycles", W'(req_cycles - snap), W'(0));
      check_idle_outputs("after_late_ack");
      mem_en = 1'b1;

      // Zero-wait memory: a load every 2 cycles, valid at request + 2
      delay = 0;
      base  = valid_cyc_q.size();
      snap  = req_cycles;
      for (int k = 0; k < 4; k++) begin
         logic [W-1:0] a;
         a = 32'h10 + 32'(4 * k);
         push_bus(1'b0, WORD, a, 32'h0);
      end
      exp_mem_q.push_back(32'h1234_5668);
      exp_mem_q.push_back(32'h1234_566C);
      exp_mem_q.push_back(32'h1234_5660);
      exp_mem_q.push_back(32'h1234_5664);
      for (int k = 0; k < 4; k++) begin
         data_req(1'b1, 1'b0, WORD, 32'h10 + 32'(4 * k), 32'h0, rcs[k]);
      end
      sample();
      sample();
      check("b2b_req_cycles", W'(req_cycles - snap), W'(4));
      if (valid_cyc_q.size() < base + 4) begin
         fail_now("b2b_valid_count", "got fewer than 4 mem_valid_o pulses, expected 4");
      end else begin
         for (int k = 0; k < 4; k++) begin
            check($sformatf("b2b_latency_%0d", k), W'(valid_cyc_q[base + k] - rcs[k]), W'(2));
         end
         for (int k = 0; k < 3; k++) begin
            check($sformatf("b2b_spacing_%0d", k),
                  W'(valid_cyc_q[base + k + 1] - valid_cyc_q[base + k]), W'(2));
         end
      end

      // Everything queued must have been consumed
      sample();
      check("exp_bus_q_drained", W'(exp_bus_q.size()), W'(0));
      check("exp_mem_q_drained", W'(exp_mem_q.size()), W'(0));
      check("exp_if_q_drained",  W'(exp_if_q.size()), W'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
